// File: rtl/imem_fetch_queue.sv
// imem_fetch_queue: byte-addressed instruction memory feeding a show-ahead
// fetch queue. Sequential words are fetched from an internal PC. Each word is
// buffered with its address and a fault flag, then presented to decode over a
// valid/ready handshake. A redirect flushes the queue and reloads the PC.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   redirect_valid/_pc    load new fetch PC and flush queued entries
//   out_valid/out_ready   head-entry handshake
//   out_pc/out_instr      head entry address and big-endian instruction word
//   out_fault             head entry was misaligned or out of range (NOP)
//   wr_en/wr_addr/wr_data/wr_be  loader port (only with IMEM_WRITE_PORT_EN)
//
// Build option: define IMEM_WRITE_PORT_EN to add the byte-enabled loader port.
// Without it the memory is read-only.
module imem_fetch_queue #(
    parameter int unsigned MEM_BYTES  = 256,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [31:0] RESET_PC   = 32'h0,
    parameter string       INIT_FILE  = ""
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        out_fault
`ifdef IMEM_WRITE_PORT_EN
    ,
    input  logic        wr_en,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_data,
    input  logic [3:0]  wr_be
`endif
);

    localparam int unsigned AW = $clog2(MEM_BYTES);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic {ST_FETCH, ST_HALT} state_e;

    logic [7:0] mem [MEM_BYTES];

    state_e          state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     q_pc_q    [FIFO_DEPTH];
    logic [31:0]     q_pc_d    [FIFO_DEPTH];
    logic [31:0]     q_instr_q [FIFO_DEPTH];
    logic [31:0]     q_instr_d [FIFO_DEPTH];
    logic            q_fault_q [FIFO_DEPTH];
    logic            q_fault_d [FIFO_DEPTH];
    logic            out_valid_q, out_valid_d;
    logic [31:0]     out_pc_q, out_pc_d;
    logic [31:0]     out_instr_q, out_instr_d;
    logic            out_fault_q, out_fault_d;

    logic            pop_c;
    logic            issue_c;
    logic            fetch_fault_c;
    logic [31:0]     fetch_word_c;
    logic [AW-1:0]   rd_base_c;

    // Memory image: zero fill.
    initial begin
        for (int i = 0; i < int'(MEM_BYTES); i++) mem[i] = 8'h00;
    end

`ifdef IMEM_WRITE_PORT_EN
    logic [AW-1:0] wr_base_c;
    assign wr_base_c = {wr_addr[AW-1:2], 2'b00};

    // Loader writes land at the edge, so a fetch in the same cycle sees old data.
    always_ff @(posedge clk) begin
        if (wr_en && (wr_addr[1:0] == 2'b00) && (wr_addr <= LAST_WORD)) begin
            if (wr_be[3]) mem[wr_base_c]            <= wr_data[31:24];
            if (wr_be[2]) mem[wr_base_c + AW'(1)]   <= wr_data[23:16];
            if (wr_be[1]) mem[wr_base_c + AW'(2)]   <= wr_data[15:8];
            if (wr_be[0]) mem[wr_base_c + AW'(3)]   <= wr_data[7:0];
        end
    end
`endif

    // Word read at the fetch PC; faulting addresses return a NOP.
    assign rd_base_c     = {fetch_pc_q[AW-1:2], 2'b00};
    assign fetch_fault_c = (fetch_pc_q[1:0] != 2'b00) || (fetch_pc_q > LAST_WORD);

    always_comb begin
        fetch_word_c = NOP_INSTR;
        if (!fetch_fault_c) begin
            fetch_word_c = {mem[rd_base_c], mem[rd_base_c + AW'(1)],
                            mem[rd_base_c + AW'(2)], mem[rd_base_c + AW'(3)]};
        end
    end

    // A full queue can still accept a fetch when its head leaves this cycle.
    assign pop_c   = out_valid_q && out_ready;
    assign issue_c = (state_q == ST_FETCH) && !redirect_valid &&
                     ((count_q < CW'(FIFO_DEPTH)) || pop_c);

    // Next-state, queue update and registered head selection.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        q_pc_d     = q_pc_q;
        q_instr_d  = q_instr_q;
        q_fault_d  = q_fault_q;

        if (redirect_valid) begin
            // The head may still transfer; everything behind it is dropped.
            fetch_pc_d = redirect_pc;
            state_d    = ST_FETCH;
            rd_ptr_d   = wr_ptr_q;
            count_d    = '0;
        end else begin
            if (pop_c) rd_ptr_d = rd_ptr_q + PW'(1);
            if (issue_c) begin
                q_pc_d[wr_ptr_q]    = fetch_pc_q;
                q_instr_d[wr_ptr_q] = fetch_word_c;
                q_fault_d[wr_ptr_q] = fetch_fault_c;
                wr_ptr_d            = wr_ptr_q + PW'(1);
                fetch_pc_d          = fetch_pc_q + 32'd4;
                if (fetch_fault_c) state_d = ST_HALT;
            end
            count_d = count_q + CW'(issue_c) - CW'(pop_c);
        end

        // Head is taken from the post-update queue so a fresh entry shows next cycle.
        out_valid_d = (count_d != '0);
        out_pc_d    = q_pc_d[rd_ptr_d];
        out_instr_d = q_instr_d[rd_ptr_d];
        out_fault_d = q_fault_d[rd_ptr_d];
    end

    // State and queue registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_FETCH;
            fetch_pc_q  <= RESET_PC;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_pc_q    <= '0;
            out_instr_q <= '0;
            out_fault_q <= 1'b0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                q_pc_q[i]    <= '0;
                q_instr_q[i] <= '0;
                q_fault_q[i] <= 1'b0;
            end
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_pc_q    <= out_pc_d;
            out_instr_q <= out_instr_d;
            out_fault_q <= out_fault_d;
            q_pc_q      <= q_pc_d;
            q_instr_q   <= q_instr_d;
            q_fault_q   <= q_fault_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_pc    = out_pc_q;
    assign out_instr = out_instr_q;
    assign out_fault = out_fault_q;

endmodule

// File: tb/tb_imem_fetch_queue.sv
// Directed bench for imem_fetch_queue. A reference image of memory drives a
// scoreboard of expected {pc, instr, fault} entries, reloaded on reset and on
// each redirect and popped on every handshake transfer. Cycle-exact checks
// cover latency, stall hold, redirect bubble, fault halt and loader writes.
module tb_imem_fetch_queue;

    localparam int unsigned MEM_BYTES = 256;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } ent_t;

    logic        clk;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_fault;
`ifdef IMEM_WRITE_PORT_EN
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
`endif

    logic [7:0] img [MEM_BYTES];
    ent_t       sb [$];
    int         vectors;
    int         miscompares;

    imem_fetch_queue dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .out_fault      (out_fault)
`ifdef IMEM_WRITE_PORT_EN
        ,
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .wr_be          (wr_be)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model_word(input logic [31:0] pc);
        int a;
        a = int'(pc);
        return {img[a], img[a + 1], img[a + 2], img[a + 3]};
    endfunction

    // Expected stream from a start PC: sequential words up to and including a fault.
    task automatic sb_load(input logic [31:0] start);
        logic [31:0] pc;
        logic        f;
        sb.delete();
        pc = start;
        for (int k = 0; k < 80; k++) begin
            f = (pc[1:0] != 2'b00) || (pc > 32'(MEM_BYTES - 4));
            sb.push_back('{pc: pc, instr: (f ? NOP_INSTR : model_word(pc)), fault: f});
            if (f) break;
            pc = pc + 32'd4;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: scoreboard the current cycle at the falling edge, return just after the rising edge.
    task automatic tick();
        ent_t e;
        @(negedge clk);
        if (!rst_n) begin
            sb_load(32'h0);
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_pc", out_pc, 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    chk("sb_pc", out_pc, e.pc);
                    chk("sb_instr", out_instr, e.instr);
                    chk("sb_fault", 32'(out_fault), 32'(e.fault));
                end
            end
            if (redirect_valid) sb_load(redirect_pc);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_pc", out_pc, 32'd0);
        chk("rst_instr", out_instr, 32'd0);
        chk("rst_fault", 32'(out_fault), 32'd0);
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        tick();
        redirect_valid = 1'b0;
    endtask

    initial begin
        vectors        = 0;
        miscompares    = 0;
        rst_n          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b1;
`ifdef IMEM_WRITE_PORT_EN
        wr_en   = 1'b0;
        wr_addr = 32'h0;
        wr_data = 32'h0;
        wr_be   = 4'h0;
`endif
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < int'(MEM_BYTES); i++) img[i] = 8'(i * 7 + 3);
        img[0] = 8'hFF; img[1] = 8'h71; img[2] = 8'h83; img[3] = 8'h93;
        img[4] = 8'h00; img[5] = 8'h40; img[6] = 8'h26; img[7] = 8'h23;
        for (int i = 0; i < int'(MEM_BYTES); i++) dut.mem[i] = img[i];

        // Power-up: outputs cleared, then one word per cycle from address 0.
        tick();
        tick();
        chk_reset_outputs();
        rst_n = 1'b1;
        chk("rel_valid", 32'(out_valid), 32'd0);
        tick();
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_pc0", out_pc, 32'h0);
        chk("t1_instr0", out_instr, 32'hFF71_8393);
        chk("t1_fault0", 32'(out_fault), 32'd0);
        tick();
        chk("t1_pc4", out_pc, 32'h4);
        chk("t1_instr4", out_instr, 32'h0040_2623);

        // Reset mid-stream, then stall: head holds, queue fills, drain has no gaps.
        rst_n = 1'b0;
        #1;
        chk_reset_outputs();
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_pc", out_pc, 32'h0);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("drain_valid", 32'(out_valid), 32'd1);
            chk("drain_pc", out_pc, 32'(4 * (k + 1)));
            chk("drain_instr", out_instr, model_word(32'(4 * (k + 1))));
        end

        // Redirect with a full queue: head transfers, one bubble, then the new PC.
        rst_n = 1'b0;
        #1;
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        out_ready = 1'b1;
        do_redirect(32'h20);
        chk("redir_bubble", 32'(out_valid), 32'd0);
        tick();
        chk("redir_valid", 32'(out_valid), 32'd1);
        chk("redir_pc", out_pc, 32'h20);
        chk("redir_instr", out_instr, model_word(32'h20));

        // Back-to-back redirects: only the second one is fetched.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80;
        tick();
        do_redirect(32'h60);
        tick();
        chk("b2b_pc", out_pc, 32'h60);

        // Misaligned redirect: a single faulting NOP, then halted until redirected.
        do_redirect(32'h22);
        chk("mis_bubble", 32'(out_valid), 32'd0);
        tick();
        chk("mis_valid", 32'(out_valid), 32'd1);
        chk("mis_pc", out_pc, 32'h22);
        chk("mis_instr", out_instr, NOP_INSTR);
        chk("mis_fault", 32'(out_fault), 32'd1);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("halt_valid", 32'(out_valid), 32'd0);
        end
        do_redirect(32'h0);
        tick();
        chk("resume_valid", 32'(out_valid), 32'd1);
        chk("resume_pc", out_pc, 32'h0);

        // End of memory: last two words normal, the next faults and fetching stops.
        do_redirect(32'hF8);
        tick();
        chk("end_pcF8", out_pc, 32'hF8);
        chk("end_faultF8", 32'(out_fault), 32'd0);
        tick();
        chk("end_pcFC", out_pc, 32'hFC);
        chk("end_instrFC", out_instr, model_word(32'hFC));
        chk("end_faultFC", 32'(out_fault), 32'd0);
        tick();
        chk("end_pc100", out_pc, 32'h100);
        chk("end_instr100", out_instr, NOP_INSTR);
        chk("end_fault100", 32'(out_fault), 32'd1);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("end_halt_valid", 32'(out_valid), 32'd0);
        end

`ifdef IMEM_WRITE_PORT_EN
        // Loader: full-word write, single-byte write, and an ignored misaligned write.
        wr_en = 1'b1; wr_addr = 32'h40; wr_data = 32'h00A0_0093; wr_be = 4'b1111;
        tick();
        img[8'h40] = 8'h00; img[8'h41] = 8'hA0; img[8'h42] = 8'h00; img[8'h43] = 8'h93;
        wr_addr = 32'h40; wr_data = 32'h1122_3344; wr_be = 4'b0001;
        do_redirect(32'h80);
        wr_en = 1'b0;
        tick();
        chk("wr_same_cycle_old", out_pc, 32'h80);
        do_redirect(32'h40);
        tick();
        chk("wr_word_instr", out_instr, 32'h00A0_0044);
        img[8'h43] = 8'h44;
        tick();
        tick();
        wr_en = 1'b1; wr_addr = 32'h41; wr_data = 32'hDEAD_BEEF; wr_be = 4'b1111;
        tick();
        wr_en = 1'b0;
        do_redirect(32'h40);
        tick();
        chk("wr_misaligned_ignored", out_instr, 32'h00A0_0044);
`endif

        for (int k = 0; k < 80; k++) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
